// File: rtl/frontend_pkg.sv
// -----------------------------------------------------------------------------
// frontend_pkg
// Definitions shared by the measurement front-end and the secant current
// controller: the default data-path width and the q_sampler state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package frontend_pkg;

   // Width of the current command, ADC samples and the averaged measurement.
   localparam int BUS_WIDTH_DEFAULT = 10;

   // q_sampler measurement-loop states.
   typedef enum logic [2:0] {
      QS_IDLE,     // loop disabled
      QS_SETTLE,   // waiting for the plant to settle after a command change
      QS_START,    // one-cycle conversion request
      QS_WAIT,     // waiting for the conversion result or a timeout
      QS_PUBLISH   // averaged result presented with the ready strobe
   } qs_state_t;

endpackage

// File: rtl/sample_averager.sv
// -----------------------------------------------------------------------------
// sample_averager
// Accumulates ADC samples for one measurement and produces the rounded mean
// of 2**AVG_LOG2 samples. The mean and the done flag look ahead at the sample
// being added, so the caller can register the result on the same edge that
// accepts the final sample.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   i_clear  in   discard the accumulator and sample count
//   i_add    in   add i_data to the accumulator this cycle
//   i_data   in   sample value (BUS_WIDTH)
//   o_done   out  this add completes the set of 2**AVG_LOG2 samples
//   o_avg    out  rounded mean including the sample being added (BUS_WIDTH)
// -----------------------------------------------------------------------------
module sample_averager
   import frontend_pkg::*;
#(
   parameter int BUS_WIDTH = BUS_WIDTH_DEFAULT,
   parameter int AVG_LOG2  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_clear,
   input  logic                 i_add,
   input  logic [BUS_WIDTH-1:0] i_data,
   output logic                 o_done,
   output logic [BUS_WIDTH-1:0] o_avg
);

   localparam int ACC_W   = BUS_WIDTH + AVG_LOG2 + 1;
   localparam int CNT_W   = AVG_LOG2 + 1;
   localparam int SAMPLES = 2 ** AVG_LOG2;
   // Half an LSB of the shifted result; evaluates to 0 when AVG_LOG2 is 0.
   localparam int HALF    = SAMPLES / 2;

   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_count;

   logic [ACC_W-1:0] w_sum;
   logic [ACC_W-1:0] w_rounded;
   logic [ACC_W-1:0] w_shifted;
   logic             w_unused_hi;

   assign w_sum     = r_acc + ACC_W'(i_data);
   assign w_rounded = w_sum + ACC_W'(HALF);
   assign w_shifted = w_rounded >> AVG_LOG2;
   // The rounded mean of in-range samples never exceeds 2**BUS_WIDTH-1, so
   // the bits above BUS_WIDTH are always zero.
   assign w_unused_hi = ^w_shifted[ACC_W-1:BUS_WIDTH];

   assign o_avg  = w_shifted[BUS_WIDTH-1:0];
   assign o_done = i_add && (r_count == CNT_W'(SAMPLES - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_acc   <= '0;
         r_count <= '0;
      end else if (i_add) begin
         r_acc   <= w_sum;
         r_count <= r_count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/q_sampler.sv
// -----------------------------------------------------------------------------
// q_sampler
// Measurement front-end for the secant current controller. Waits a settling
// time after every change of the current command, requests a burst of ADC
// conversions, averages them and publishes the result with a ready strobe.
// Runs back-to-back while enabled and the command is stable.
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   enable       in   run the measurement loop
//   i_ref        in   current command from the controller (BUS_WIDTH)
//   adc_data     in   conversion result, valid with adc_valid (BUS_WIDTH)
//   adc_valid    in   one-cycle conversion-done strobe
//   adc_start    out  one-cycle conversion request
//   q_measured   out  averaged measurement, held between updates (BUS_WIDTH)
//   ready        out  one-cycle strobe: q_measured updated this cycle
//   busy         out  loop is in any state other than IDLE
//   adc_timeout  out  sticky conversion-timeout flag, cleared only by rst
// -----------------------------------------------------------------------------
module q_sampler
   import frontend_pkg::*;
#(
   parameter int BUS_WIDTH     = BUS_WIDTH_DEFAULT,
   parameter int SETTLE_CYCLES = 64,    // >= 1
   parameter int AVG_LOG2      = 2,     // 0..4
   parameter int ADC_TIMEOUT   = 255    // >= 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [BUS_WIDTH-1:0] i_ref,
   input  logic [BUS_WIDTH-1:0] adc_data,
   input  logic                 adc_valid,
   output logic                 adc_start,
   output logic [BUS_WIDTH-1:0] q_measured,
   output logic                 ready,
   output logic                 busy,
   output logic                 adc_timeout
);

   localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
   localparam int TMO_W    = $clog2(ADC_TIMEOUT + 1);
   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);
   localparam logic [TMO_W-1:0]    TMO_LOAD    = TMO_W'(ADC_TIMEOUT);

   qs_state_t            r_state;
   logic [BUS_WIDTH-1:0] r_i_ref_q;
   logic [SETTLE_W-1:0]  r_settle_cnt;
   logic [TMO_W-1:0]     r_tmo_cnt;
   logic                 r_adc_start;
   logic [BUS_WIDTH-1:0] r_q_measured;
   logic                 r_ready;
   logic                 r_busy;
   logic                 r_adc_timeout;

   logic                 w_ref_changed;
   logic                 w_avg_clear;
   logic                 w_avg_add;
   logic                 w_avg_done;
   logic [BUS_WIDTH-1:0] w_avg_value;

   assign w_ref_changed = (i_ref != r_i_ref_q);

   // The accumulator only survives across START/WAIT; every other state
   // either starts a fresh measurement or has abandoned the current one.
   assign w_avg_clear = (r_state != QS_START) && (r_state != QS_WAIT);
   // A sample arriving together with a command change belongs to the old
   // operating point and is dropped.
   assign w_avg_add   = enable && (r_state == QS_WAIT) && adc_valid && !w_ref_changed;

   sample_averager #(
      .BUS_WIDTH (BUS_WIDTH),
      .AVG_LOG2  (AVG_LOG2)
   ) u_averager (
      .clk     (clk),
      .rst     (rst),
      .i_clear (w_avg_clear),
      .i_add   (w_avg_add),
      .i_data  (adc_data),
      .o_done  (w_avg_done),
      .o_avg   (w_avg_value)
   );

   // Outputs are registered on the transition into the state they belong to,
   // so adc_start is high during START and ready is high during PUBLISH.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous: it is just the highest-priority branch
      // of the clocked block, not part of the sensitivity list.
      if (rst) begin
         r_state       <= QS_IDLE;
         r_i_ref_q     <= '0;
         r_settle_cnt  <= '0;
         r_tmo_cnt     <= '0;
         r_adc_start   <= 1'b0;
         r_q_measured  <= '0;
         r_ready       <= 1'b0;
         r_busy        <= 1'b0;
         r_adc_timeout <= 1'b0;
      end else begin
         r_i_ref_q   <= i_ref;
         r_adc_start <= 1'b0;
         r_ready     <= 1'b0;

         if (!enable) begin
            r_state <= QS_IDLE;
            r_busy  <= 1'b0;
         end else begin
            // Every successor of an enabled state is an active state.
            r_busy <= 1'b1;
            case (r_state)
               QS_IDLE: begin
                  r_state      <= QS_SETTLE;
                  r_settle_cnt <= SETTLE_LOAD;
               end

               QS_SETTLE: begin
                  if (w_ref_changed) begin
                     r_settle_cnt <= SETTLE_LOAD;
                  end else if (r_settle_cnt == SETTLE_W'(1)) begin
                     // Counter reaches zero on this edge: settling complete.
                     r_state     <= QS_START;
                     r_adc_start <= 1'b1;
                  end else begin
                     r_settle_cnt <= r_settle_cnt - SETTLE_W'(1);
                  end
               end

               QS_START: begin
                  if (w_ref_changed) begin
                     r_state      <= QS_SETTLE;
                     r_settle_cnt <= SETTLE_LOAD;
                  end else begin
                     r_state   <= QS_WAIT;
                     r_tmo_cnt <= TMO_LOAD;
                  end
               end

               QS_WAIT: begin
                  if (w_ref_changed) begin
                     r_state      <= QS_SETTLE;
                     r_settle_cnt <= SETTLE_LOAD;
                  end else if (adc_valid) begin
                     if (w_avg_done) begin
                        r_state      <= QS_PUBLISH;
                        r_q_measured <= w_avg_value;
                        r_ready      <= 1'b1;
                     end else begin
                        r_state     <= QS_START;
                        r_adc_start <= 1'b1;
                     end
                  end else if (r_tmo_cnt == TMO_W'(1)) begin
                     // Last allowed WAIT cycle without a result: retry the
                     // same sample; the averager count is left untouched.
                     r_adc_timeout <= 1'b1;
                     r_state       <= QS_START;
                     r_adc_start   <= 1'b1;
                  end else begin
                     r_tmo_cnt <= r_tmo_cnt - TMO_W'(1);
                  end
               end

               QS_PUBLISH: begin
                  // A change in any earlier active state already aborted to
                  // SETTLE, so only a change in this cycle needs re-settling.
                  if (w_ref_changed) begin
                     r_state      <= QS_SETTLE;
                     r_settle_cnt <= SETTLE_LOAD;
                  end else begin
                     r_state     <= QS_START;
                     r_adc_start <= 1'b1;
                  end
               end

               default: begin
                  r_state <= QS_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign adc_start   = r_adc_start;
   assign q_measured  = r_q_measured;
   assign ready       = r_ready;
   assign busy        = r_busy;
   assign adc_timeout = r_adc_timeout;

endmodule
